ledbanner_ctrl: RTL

//  Mode sequencer for the 8-LED banner: runs a one-hot pattern in rotate-left, rotate-right
//  or bounce mode at a selectable step rate, with pause/resume. Sits between debounced

---
 rtl/ledbanner_pkg.sv | 43 ++++
 rtl/ledbanner_if.sv | 25 ++
 rtl/ledbanner_shift.sv | 56 +++++
 rtl/ledbanner_ctrl.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ledbanner_pkg.sv
// -----------------------------------------------------------------------------
// ledbanner_pkg
// Shared definitions for the 8-LED banner controller.
//   - state_e      : controller state encoding, also driven out on mode_o
//   - SEED_DEFAULT : pattern loaded on start and on zero-pattern recovery
//   - DIR_L/DIR_R  : shift direction encoding used by controller and datapath
//   - next_run_mode: run-mode cycling order on a mode button press
//   - is_run_state : true for the three pattern-moving states
// -----------------------------------------------------------------------------
package ledbanner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_ROT_L  = 3'd2,
        ST_ROT_R  = 3'd3,
        ST_BOUNCE = 3'd4,
        ST_PAUSE  = 3'd5
    } state_e;

    localparam logic [7:0] SEED_DEFAULT = 8'b0000_0001;

    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

    // Run-mode order: ROT_L -> ROT_R -> BOUNCE -> ROT_L.
    function automatic state_e next_run_mode(input state_e cur);
        case (cur)
            ST_ROT_L:  return ST_ROT_R;
            ST_ROT_R:  return ST_BOUNCE;
            ST_BOUNCE: return ST_ROT_L;
            default:   return ST_ROT_L;
        endcase
    endfunction

    function automatic logic is_run_state(input state_e s);
        case (s)
            ST_ROT_L, ST_ROT_R, ST_BOUNCE: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ledbanner_if.sv
// -----------------------------------------------------------------------------
// ledbanner_if
// Button/speed inputs and LED/status outputs of the banner controller.
//   master : board side (drives btn_mode, btn_pause, speed; reads led, mode_o)
//   slave  : controller side
// Optional build macro: LEDBANNER_STEPCNT_EN adds step_cnt[7:0].
// -----------------------------------------------------------------------------
interface ledbanner_if #(
    parameter int DIV_W = 2
);
    logic             btn_mode;
    logic             btn_pause;
    logic [DIV_W-1:0] speed;
    logic [7:0]       led;
    logic [2:0]       mode_o;
`ifdef LEDBANNER_STEPCNT_EN
    logic [7:0]       step_cnt;

    modport master (output btn_mode, btn_pause, speed, input led, mode_o, step_cnt);
    modport slave  (input btn_mode, btn_pause, speed, output led, mode_o, step_cnt);
`else
    modport master (output btn_mode, btn_pause, speed, input led, mode_o);
    modport slave  (input btn_mode, btn_pause, speed, output led, mode_o);
`endif
endinterface

// File: rtl/ledbanner_shift.sv
// -----------------------------------------------------------------------------
// ledbanner_shift
// 8-bit pattern register for the banner.
//   clk6Hz  in  system clock
//   rst_n   in  asynchronous active-low reset (clears pattern to 0)
//   load_i  in  load seed_i (has priority over step_i)
//   seed_i  in  pattern to load
//   step_i  in  shift one position
//   dir_i   in  DIR_L = towards bit 7, DIR_R = towards bit 0
//   wrap_i  in  1 = rotate, 0 = shift in zero
//   q_o     out current pattern
// -----------------------------------------------------------------------------
module ledbanner_shift
    import ledbanner_pkg::*;
(
    input  logic       clk6Hz,
    input  logic       rst_n,
    input  logic       load_i,
    input  logic [7:0] seed_i,
    input  logic       step_i,
    input  logic       dir_i,
    input  logic       wrap_i,
    output logic [7:0] q_o
);

    logic [7:0] q_q;
    logic [7:0] q_d;

    // Next pattern: load, shift/rotate, or hold.
    always_comb begin
        q_d = q_q;
        if (load_i) begin
            q_d = seed_i;
        end else if (step_i) begin
            if (dir_i == DIR_L) begin
                q_d = {q_q[6:0], (wrap_i ? q_q[7] : 1'b0)};
            end else begin
                q_d = {(wrap_i ? q_q[0] : 1'b0), q_q[7:1]};
            end
        end else begin
            q_d = q_q;
        end
    end

    // Pattern register.
    always_ff @(posedge clk6Hz or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= 8'h00;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/ledbanner_ctrl.sv
// -----------------------------------------------------------------------------
// ledbanner_ctrl
// Mode sequencer for the 8-LED banner: rotate-left, rotate-right or bounce at a
// selectable step rate, with pause/resume.
//   clk6Hz  in  system clock
//   rst_n   in  asynchronous active-low reset
//   bus     slave modport of ledbanner_if:
//             btn_mode  in  start / next mode (1-cycle pulse)
//             btn_pause in  toggle pause (1-cycle pulse, wins over btn_mode)
//             speed     in  one step every speed+1 clocks
//             led       out banner pattern
//             mode_o    out current state encoding
//             step_cnt  out executed steps (only with LEDBANNER_STEPCNT_EN)
// Optional build macro: LEDBANNER_STEPCNT_EN.
// -----------------------------------------------------------------------------
module ledbanner_ctrl
    import ledbanner_pkg::*;
#(
    parameter logic [7:0] SEED  = SEED_DEFAULT,
    parameter int         DIV_W = 2
) (
    input  logic  clk6Hz,
    input  logic  rst_n,
    ledbanner_if.slave bus
);

    state_e           state_q, state_d;
    state_e           saved_q, saved_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             dir_q, dir_d;

    logic [7:0]       led_s;
    logic [7:0]       bounce_next_s;
    logic [7:0]       next_pat_s;
    logic             rollover_s;
    logic             step_s;
    logic             load_s;
    logic             shift_dir_s;
    logic             wrap_s;

    // >= so that lowering speed below the current count rolls over at once.
    assign rollover_s = (div_q >= bus.speed);

    // Bounce shift result without wrap; used to decide the direction flip.
    assign bounce_next_s = (dir_q == DIR_L) ? {led_s[6:0], 1'b0} : {1'b0, led_s[7:1]};
    assign next_pat_s    = (led_s == 8'h00) ? SEED : bounce_next_s;

    // Next-state, datapath controls, divider and bounce direction.
    always_comb begin
        state_d     = state_q;
        saved_d     = saved_q;
        div_d       = div_q;
        dir_d       = dir_q;
        step_s      = 1'b0;
        load_s      = 1'b0;
        shift_dir_s = DIR_L;
        wrap_s      = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (bus.btn_mode) begin
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                load_s  = 1'b1;
                dir_d   = DIR_L;
                state_d = ST_ROT_L;
            end
            ST_ROT_L, ST_ROT_R, ST_BOUNCE: begin
                if (state_q == ST_ROT_R) begin
                    shift_dir_s = DIR_R;
                    wrap_s      = 1'b1;
                end else if (state_q == ST_BOUNCE) begin
                    shift_dir_s = dir_q;
                    wrap_s      = 1'b0;
                end else begin
                    shift_dir_s = DIR_L;
                    wrap_s      = 1'b1;
                end

                if (bus.btn_pause) begin
                    saved_d = state_q;
                    state_d = ST_PAUSE;
                end else if (bus.btn_mode) begin
                    state_d = next_run_mode(state_q);
                    // Entering bounce at an end points the direction away from it.
                    if (state_d == ST_BOUNCE) begin
                        if (led_s[7]) begin
                            dir_d = DIR_R;
                        end else if (led_s[0]) begin
                            dir_d = DIR_L;
                        end else begin
                            dir_d = dir_q;
                        end
                    end else begin
                        dir_d = dir_q;
                    end
                end else begin
                    step_s = rollover_s;
                    // Zero guard: a step on an empty pattern reloads the seed.
                    load_s = rollover_s && (led_s == 8'h00);
                    if (step_s && (state_q == ST_BOUNCE)) begin
                        if (next_pat_s[7]) begin
                            dir_d = DIR_R;
                        end else if (next_pat_s[0]) begin
                            dir_d = DIR_L;
                        end else begin
                            dir_d = dir_q;
                        end
                    end else begin
                        dir_d = dir_q;
                    end
                end
            end
            ST_PAUSE: begin
                if (bus.btn_pause) begin
                    state_d = saved_q;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Divider restarts on every state change and only runs in run states.
        if (state_d != state_q) begin
            div_d = '0;
        end else if (is_run_state(state_q)) begin
            if (rollover_s) begin
                div_d = '0;
            end else begin
                div_d = div_q + DIV_W'(1);
            end
        end else begin
            div_d = div_q;
        end
    end

    // Controller state registers.
    always_ff @(posedge clk6Hz or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            saved_q <= ST_ROT_L;
            div_q   <= '0;
            dir_q   <= DIR_L;
        end else begin
            state_q <= state_d;
            saved_q <= saved_d;
            div_q   <= div_d;
            dir_q   <= dir_d;
        end
    end

    ledbanner_shift u_shift (
        .clk6Hz (clk6Hz),
        .rst_n  (rst_n),
        .load_i (load_s),
        .seed_i (SEED),
        .step_i (step_s),
        .dir_i  (shift_dir_s),
        .wrap_i (wrap_s),
        .q_o    (led_s)
    );

    assign bus.led    = led_s;
    assign bus.mode_o = state_q;

`ifdef LEDBANNER_STEPCNT_EN
    logic [7:0] step_cnt_q;

    // Executed-step counter; cleared on (re)start, naturally holds in PAUSE.
    always_ff @(posedge clk6Hz or negedge rst_n) begin
        if (!rst_n) begin
            step_cnt_q <= 8'h00;
        end else if (state_q == ST_LOAD) begin
            step_cnt_q <= 8'h00;
        end else if (step_s) begin
            step_cnt_q <= step_cnt_q + 8'h01;
        end else begin
            step_cnt_q <= step_cnt_q;
        end
    end

    assign bus.step_cnt = step_cnt_q;
`endif

endmodule
